// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
// Receive side of the multiplexed seven-segment display path. The block samples
// the scanned anode/cathode lines and waits until a digit slot has been steady
// long enough to be free of ghosting. It then decodes the segment pattern back
// to BCD and assembles the eight slots into a frame.
// Optional feature macro: SSEG_DP_CAPTURE_EN. When it is defined, the decimal
// points are captured and reported on dpOut. When it is not defined, the dp
// line is ignored and dpOut reads 8'h00.
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [7:0]  aSegIn,
    input  logic [7:0]  cSegIn,
    output logic [31:0] digitsOut,
    output logic [7:0]  dpOut,
    output logic        frameValidOut,
    output logic        patternErrOut,
    output logic        staleOut
);

    localparam int STABLE_W = $clog2(STABLE_CYCLES) + 1;
    localparam int IDLE_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(STABLE_CYCLES);
    localparam logic [STABLE_W-1:0] STABLE_ONE = STABLE_W'(1);
    localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);

`ifdef SSEG_DP_CAPTURE_EN
    localparam int C_W = 8;
`else
    localparam int C_W = 7;
`endif

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scanState_t;

    scanState_t         state;
    logic [STABLE_W-1:0] stableCnt;
    logic [IDLE_W-1:0]   idleCnt;

    logic [7:0]     aReg;
    logic [C_W-1:0] cReg;
    logic [7:0]     aPrev;
    logic [C_W-1:0] cPrev;

    logic [3:0] zeroCount;
    logic [2:0] slotIdx;
    logic       validSlot;
    logic [6:0] segOn;
    logic [3:0] decodedDigit;
    logic       decodeErr;
    logic       sameSample;
    logic       aChanged;
    logic       captureNow;

    logic [7:0]       bitmap;
    logic [7:0]       mergedBitmap;
    logic             errFlag;
    logic [7:0][3:0]  shadowDigits;
    logic [7:0][3:0]  mergedDigits;

`ifdef SSEG_DP_CAPTURE_EN
    logic [7:0] shadowDp;
    logic [7:0] mergedDp;
`else
    logic unusedDp;
    assign unusedDp = cSegIn[7];
    assign dpOut    = 8'h00;
`endif

    // Register the scanned lines once, and keep the previous sample for change detection
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            aReg  <= 8'hFF;
            cReg  <= '1;
            aPrev <= 8'hFF;
            cPrev <= '1;
        end else begin
            aReg  <= aSegIn;
            cReg  <= cSegIn[C_W-1:0];
            aPrev <= aReg;
            cPrev <= cReg;
        end
    end

    // A slot is valid only when exactly one anode is low; its position is the slot index
    always_comb begin
        zeroCount = 4'd0;
        slotIdx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!aReg[i]) begin
                zeroCount = zeroCount + 4'd1;
                slotIdx   = 3'(i);
            end
        end
        validSlot = (zeroCount == 4'd1);
    end

    // Map the lit segments {g,f,e,d,c,b,a} back to BCD; anything else is undecodable
    always_comb begin
        segOn        = ~cReg[6:0];
        decodedDigit = 4'hF;
        decodeErr    = 1'b0;
        case (segOn)
            7'h3F:   decodedDigit = 4'd0;
            7'h06:   decodedDigit = 4'd1;
            7'h5B:   decodedDigit = 4'd2;
            7'h4F:   decodedDigit = 4'd3;
            7'h66:   decodedDigit = 4'd4;
            7'h6D:   decodedDigit = 4'd5;
            7'h7D:   decodedDigit = 4'd6;
            7'h07:   decodedDigit = 4'd7;
            7'h7F:   decodedDigit = 4'd8;
            7'h6F:   decodedDigit = 4'd9;
            default: begin
                decodedDigit = 4'hF;
                decodeErr    = 1'b1;
            end
        endcase
    end

    // A capture happens on the edge where the run of identical samples reaches STABLE_CYCLES
    always_comb begin
        sameSample = (aReg == aPrev) && (cReg == cPrev);
        aChanged   = (aReg != aPrev);
        captureNow = (state == SETTLE) && sameSample && (stableCnt == STABLE_MAX - STABLE_ONE);
    end

    // Merge the digit being captured into the shadows so a completing frame carries it
    always_comb begin
        mergedBitmap          = bitmap | (8'h01 << slotIdx);
        mergedDigits          = shadowDigits;
        mergedDigits[slotIdx] = decodedDigit;
`ifdef SSEG_DP_CAPTURE_EN
        mergedDp              = shadowDp;
        mergedDp[slotIdx]     = ~cReg[7];
`endif
    end

    // Scan tracking FSM: find a driven slot, wait for it to settle, then hold until the anodes move
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            state     <= SEARCH;
            stableCnt <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (validSlot) begin
                        stableCnt <= STABLE_ONE;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sameSample) begin
                        if (stableCnt == STABLE_MAX - STABLE_ONE) begin
                            stableCnt <= STABLE_MAX;
                            state     <= HOLD;
                        end else if (stableCnt != STABLE_MAX) begin
                            stableCnt <= stableCnt + STABLE_ONE;
                        end
                    end else if (validSlot) begin
                        stableCnt <= STABLE_ONE;
                    end else begin
                        state <= SEARCH;
                    end
                end
                HOLD: begin
                    if (aChanged) begin
                        state <= SEARCH;
                    end
                end
                default: begin
                    state     <= SEARCH;
                    stableCnt <= '0;
                end
            endcase
        end
    end

    // Capture into the shadows, publish a finished frame, and discard partial frames on timeout
    always_ff @(posedge clkIn or negedge rstIn) begin
        if (!rstIn) begin
            digitsOut     <= 32'h0;
            frameValidOut <= 1'b0;
            patternErrOut <= 1'b0;
            staleOut      <= 1'b0;
            bitmap        <= 8'h00;
            errFlag       <= 1'b0;
            shadowDigits  <= '0;
            idleCnt       <= '0;
`ifdef SSEG_DP_CAPTURE_EN
            shadowDp      <= 8'h00;
            dpOut         <= 8'h00;
`endif
        end else begin
            frameValidOut <= 1'b0;
            if (captureNow) begin
                idleCnt               <= '0;
                staleOut              <= 1'b0;
                shadowDigits[slotIdx] <= decodedDigit;
`ifdef SSEG_DP_CAPTURE_EN
                shadowDp[slotIdx]     <= ~cReg[7];
`endif
                if (mergedBitmap == 8'hFF) begin
                    digitsOut     <= mergedDigits;
`ifdef SSEG_DP_CAPTURE_EN
                    dpOut         <= mergedDp;
`endif
                    patternErrOut <= errFlag | decodeErr;
                    frameValidOut <= 1'b1;
                    bitmap        <= 8'h00;
                    errFlag       <= 1'b0;
                end else begin
                    bitmap  <= mergedBitmap;
                    errFlag <= errFlag | decodeErr;
                end
            end else if (idleCnt == IDLE_MAX - IDLE_W'(1)) begin
                idleCnt  <= IDLE_MAX;
                staleOut <= 1'b1;
                bitmap   <= 8'h00;
                errFlag  <= 1'b0;
            end else if (idleCnt != IDLE_MAX) begin
                idleCnt <= idleCnt + IDLE_W'(1);
            end
        end
    end

endmodule
